bridge: RTL and testbench

BRIDGE -- requirements
Module: bridge

---
 rtl/bridge_pkg.sv | 26 ++
 rtl/bridge.sv | 119 +++++++++++
 tb/tb_bridge.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bridge_pkg.sv
// Shared types and constants for the AHB-to-APB bridge.
package bridge_pkg;

    // Bridge controller states. IDLE, RENABLE and WENABLE are the only
    // states that drive hready=1 and accept a new AHB transfer.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_RENABLE = 3'd2,
        ST_WWAIT   = 3'd3,
        ST_WRITE   = 3'd4,
        ST_WENABLE = 3'd5
    } state_e;

    // AHB HTRANS encodings.
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // A transfer is real only when selected and NONSEQ/SEQ.
    function automatic logic is_valid(input logic sel, input logic [1:0] trans);
        return sel && ((trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ));
    endfunction

endpackage

// File: rtl/bridge.sv
// AHB-to-APB bridge. Reads take READ -> RENABLE, writes take
// WWAIT -> WRITE -> WENABLE. APB outputs and hready are registered and are
// computed from the next state, so they change together with the state.
//
// Handshake: on the AHB side a transfer is accepted on a rising edge where
// hready=1 and hselapb & htrans[1] are high; hready=0 stretches the data
// phase. On the APB side psel rises for a setup cycle, penable follows for
// exactly one access cycle, and prdata is taken in the access cycle.
module bridge
    import bridge_pkg::*;
(
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        hselapb,
    input  logic        hwrite,
    input  logic [1:0]  htrans,
    input  logic [31:0] haddr,
    input  logic [31:0] hwdata,
    input  logic [31:0] prdata,
    output logic [31:0] paddr,
    output logic [31:0] pwdata,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic        hresp,
    output logic        hready,
    output logic [31:0] hrdata,
    output state_e      dbg_state
);

    state_e      state_q, state_d;
    logic [31:0] paddr_q, paddr_d;
    logic [31:0] pwdata_q, pwdata_d;
    logic        pwrite_q, pwrite_d;
    logic        psel_q, psel_d;
    logic        penable_q, penable_d;
    logic        hready_q, hready_d;
    logic        valid;

    assign valid = is_valid(hselapb, htrans);

    // Next-state decision and latching of address, direction and write data.
    always_comb begin
        state_d  = state_q;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
        case (state_q)
            ST_IDLE, ST_RENABLE, ST_WENABLE: begin
                if (valid) begin
                    paddr_d  = haddr;
                    pwrite_d = hwrite;
                    state_d  = hwrite ? ST_WWAIT : ST_READ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ:  state_d = ST_RENABLE;
            ST_WWAIT: begin
                // hwdata is valid in the data phase, i.e. this cycle.
                pwdata_d = hwdata;
                state_d  = ST_WRITE;
            end
            ST_WRITE: state_d = ST_WENABLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Registered outputs decoded from the state being entered.
    always_comb begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        hready_d  = 1'b1;
        case (state_d)
            ST_READ, ST_WRITE: begin
                psel_d   = 1'b1;
                hready_d = 1'b0;
            end
            ST_RENABLE, ST_WENABLE: begin
                psel_d    = 1'b1;
                penable_d = 1'b1;
            end
            ST_WWAIT: hready_d = 1'b0;
            default: ;
        endcase
    end

    // State and output registers; reset drops any transfer in flight.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q   <= ST_IDLE;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            hready_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pwrite_q  <= pwrite_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            hready_q  <= hready_d;
        end
    end

    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign pwrite    = pwrite_q;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign hready    = hready_q;
    assign hresp     = 1'b0;
    assign hrdata    = prdata;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_bridge.sv
// Testbench for the AHB-to-APB bridge: directed vectors, a transaction-level
// model of the expected APB/AHB outputs, and hand-computed spot checks.
module tb_bridge;
    import bridge_pkg::*;

    logic        hclk;
    logic        hresetn;
    logic        hselapb;
    logic        hwrite;
    logic [1:0]  htrans;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic [31:0] prdata;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic        hresp;
    logic        hready;
    logic [31:0] hrdata;
    state_e      dbg_state;

    int n_checks = 0;
    int n_pass   = 0;
    logic chk_en = 1'b0;

    bridge dut (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .hselapb   (hselapb),
        .hwrite    (hwrite),
        .htrans    (htrans),
        .haddr     (haddr),
        .hwdata    (hwdata),
        .prdata    (prdata),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .hresp     (hresp),
        .hready    (hready),
        .hrdata    (hrdata),
        .dbg_state (dbg_state)
    );

    // Clock.
    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // ---------------------------------------------------------------
    // Model: each accepted AHB transfer expands into the list of output
    // snapshots it must produce, one per cycle. A read is setup+access,
    // a write is wait+setup+access; write data is taken from hwdata in
    // the wait cycle. With nothing queued the bus is idle.
    // ---------------------------------------------------------------
    typedef struct packed {
        logic psel;
        logic penable;
        logic hready;
        logic cap_wdata;
    } phase_t;

    phase_t      ph_q[$];
    logic        m_psel, m_pen, m_hready, m_pwrite;
    logic [31:0] m_paddr, m_pwdata;

    always @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            ph_q.delete();
            m_psel   = 1'b0;
            m_pen    = 1'b0;
            m_hready = 1'b1;
            m_pwrite = 1'b0;
            m_paddr  = 32'h0;
            m_pwdata = 32'h0;
        end else begin
            phase_t p;
            if (m_hready && hselapb && htrans[1]) begin
                m_paddr  = haddr;
                m_pwrite = hwrite;
                if (!hwrite) begin
                    ph_q.push_back('{1'b1, 1'b0, 1'b0, 1'b0});
                    ph_q.push_back('{1'b1, 1'b1, 1'b1, 1'b0});
                end else begin
                    ph_q.push_back('{1'b0, 1'b0, 1'b0, 1'b0});
                    ph_q.push_back('{1'b1, 1'b0, 1'b0, 1'b1});
                    ph_q.push_back('{1'b1, 1'b1, 1'b1, 1'b0});
                end
            end
            if (ph_q.size() > 0) begin
                p = ph_q.pop_front();
                m_psel   = p.psel;
                m_pen    = p.penable;
                m_hready = p.hready;
                if (p.cap_wdata) m_pwdata = hwdata;
            end else begin
                m_psel   = 1'b0;
                m_pen    = 1'b0;
                m_hready = 1'b1;
            end
        end
    end

    // Scoreboard compare, away from the active edge.
    always @(negedge hclk) begin
        if (chk_en) begin
            check("cmp_psel",    {31'b0, psel},    {31'b0, m_psel});
            check("cmp_penable", {31'b0, penable}, {31'b0, m_pen});
            check("cmp_hready",  {31'b0, hready},  {31'b0, m_hready});
            check("cmp_hresp",   {31'b0, hresp},   32'h0);
            check("cmp_pwrite",  {31'b0, pwrite},  {31'b0, m_pwrite});
            check("cmp_paddr",   paddr,  m_paddr);
            check("cmp_pwdata",  pwdata, m_pwdata);
            check("cmp_hrdata",  hrdata, prdata);
        end
    end

    // Driver: apply inputs for one cycle, return just after the edge that
    // sampled them.
    task automatic drive(input logic sel, input logic wr, input logic [1:0] tr,
                         input logic [31:0] addr, input logic [31:0] wdata);
        hselapb = sel;
        hwrite  = wr;
        htrans  = tr;
        haddr   = addr;
        hwdata  = wdata;
        @(posedge hclk);
        #1;
    endtask

    task automatic idle_cycle();
        drive(1'b0, 1'b0, HTRANS_IDLE, 32'h0, 32'h0);
    endtask

    typedef struct packed {
        logic        sel;
        logic        wr;
        logic [1:0]  tr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[14];

    initial begin
        vecs[0]  = '{1'b1, 1'b1, HTRANS_NONSEQ, 32'h0000_0100, 32'h0,          32'hAAAA_0001};
        vecs[1]  = '{1'b1, 1'b0, HTRANS_SEQ,    32'h0000_0104, 32'h1111_2222,  32'hAAAA_0002};
        vecs[2]  = '{1'b0, 1'b0, HTRANS_IDLE,   32'h0,         32'h0,          32'hAAAA_0003};
        vecs[3]  = '{1'b1, 1'b0, HTRANS_NONSEQ, 32'h0000_0200, 32'h0,          32'hAAAA_0004};
        vecs[4]  = '{1'b1, 1'b1, HTRANS_BUSY,   32'h0000_0300, 32'h0,          32'hAAAA_0005};
        vecs[5]  = '{1'b1, 1'b1, HTRANS_SEQ,    32'h0000_0208, 32'h0,          32'hAAAA_0006};
        vecs[6]  = '{1'b0, 1'b0, HTRANS_BUSY,   32'h0,         32'h3333_4444,  32'hAAAA_0007};
        vecs[7]  = '{1'b0, 1'b1, HTRANS_NONSEQ, 32'h0000_0999, 32'h5555_6666,  32'hAAAA_0008};
        vecs[8]  = '{1'b1, 1'b1, HTRANS_NONSEQ, 32'h0000_020C, 32'h7777_8888,  32'hAAAA_0009};
        vecs[9]  = '{1'b0, 1'b0, HTRANS_IDLE,   32'h0,         32'h9999_0000,  32'hAAAA_000A};
        vecs[10] = '{1'b0, 1'b0, HTRANS_IDLE,   32'h0,         32'h0,          32'hAAAA_000B};
        vecs[11] = '{1'b1, 1'b0, HTRANS_NONSEQ, 32'hFFFF_FFFC, 32'h0,          32'hBBBB_CCCC};
        vecs[12] = '{1'b0, 1'b0, HTRANS_IDLE,   32'h0,         32'h0,          32'hDDDD_EEEE};
        vecs[13] = '{1'b0, 1'b0, HTRANS_IDLE,   32'h0,         32'h0,          32'h0};
    end

    // Directed test sequence.
    initial begin
        hresetn = 1'b0;
        hselapb = 1'b0;
        hwrite  = 1'b0;
        htrans  = HTRANS_IDLE;
        haddr   = 32'h0;
        hwdata  = 32'h0;
        prdata  = 32'h0;
        repeat (2) @(posedge hclk);
        #1;

        // Reset values.
        check("rst_psel",    {31'b0, psel},    32'h0);
        check("rst_penable", {31'b0, penable}, 32'h0);
        check("rst_hready",  {31'b0, hready},  32'h1);
        check("rst_hresp",   {31'b0, hresp},   32'h0);
        check("rst_paddr",   paddr,  32'h0);
        check("rst_pwdata",  pwdata, 32'h0);
        check("rst_pwrite",  {31'b0, pwrite},  32'h0);
        check("rst_state",   32'(dbg_state), 32'(ST_IDLE));
        hresetn = 1'b1;
        chk_en  = 1'b1;
        idle_cycle();

        // Single read of 0x20 returning 0x28.
        prdata = 32'h28;
        drive(1'b1, 1'b0, HTRANS_NONSEQ, 32'h20, 32'h0);
        check("rd_setup_psel",   {31'b0, psel},    32'h1);
        check("rd_setup_pen",    {31'b0, penable}, 32'h0);
        check("rd_setup_hready", {31'b0, hready},  32'h0);
        check("rd_setup_paddr",  paddr, 32'h20);
        idle_cycle();
        check("rd_access_pen",    {31'b0, penable}, 32'h1);
        check("rd_access_hready", {31'b0, hready},  32'h1);
        check("rd_access_hrdata", hrdata, 32'h28);
        idle_cycle();
        check("rd_done_psel", {31'b0, psel},    32'h0);
        check("rd_done_pen",  {31'b0, penable}, 32'h0);

        // Single write of 0xDEADBEEF to 0x40; selection dropped during wait.
        drive(1'b1, 1'b1, HTRANS_NONSEQ, 32'h40, 32'h0);
        check("wr_wait_hready", {31'b0, hready}, 32'h0);
        check("wr_wait_psel",   {31'b0, psel},   32'h0);
        drive(1'b0, 1'b0, HTRANS_IDLE, 32'h0, 32'hDEAD_BEEF);
        check("wr_setup_psel",   {31'b0, psel},   32'h1);
        check("wr_setup_pwrite", {31'b0, pwrite}, 32'h1);
        check("wr_setup_paddr",  paddr,  32'h40);
        check("wr_setup_pwdata", pwdata, 32'hDEAD_BEEF);
        idle_cycle();
        check("wr_access_pen",    {31'b0, penable}, 32'h1);
        check("wr_access_hready", {31'b0, hready},  32'h1);
        idle_cycle();
        check("wr_done_psel",   {31'b0, psel}, 32'h0);
        check("wr_hold_pwdata", pwdata, 32'hDEAD_BEEF);
        check("wr_hold_paddr",  paddr,  32'h40);

        // Back-to-back reads: 0x20 issued during the access cycle of 0x10.
        drive(1'b1, 1'b0, HTRANS_NONSEQ, 32'h10, 32'h0);
        idle_cycle();
        check("b2b_first_access", {31'b0, penable}, 32'h1);
        drive(1'b1, 1'b0, HTRANS_NONSEQ, 32'h20, 32'h0);
        check("b2b_second_psel",  {31'b0, psel},    32'h1);
        check("b2b_second_pen",   {31'b0, penable}, 32'h0);
        check("b2b_second_paddr", paddr, 32'h20);
        idle_cycle();
        idle_cycle();

        // Ignored transfers: BUSY, and NONSEQ while unselected.
        drive(1'b1, 1'b0, HTRANS_BUSY, 32'h50, 32'h0);
        check("busy_psel",   {31'b0, psel},   32'h0);
        check("busy_hready", {31'b0, hready}, 32'h1);
        drive(1'b0, 1'b0, HTRANS_NONSEQ, 32'h60, 32'h0);
        check("unsel_psel",   {31'b0, psel},   32'h0);
        check("unsel_hready", {31'b0, hready}, 32'h1);
        check("unsel_paddr",  paddr, 32'h20);

        // Mixed directed vectors, checked by the model only.
        for (int i = 0; i < 14; i++) begin
            prdata = vecs[i].rdata;
            drive(vecs[i].sel, vecs[i].wr, vecs[i].tr, vecs[i].addr, vecs[i].wdata);
        end

        // Reset in the middle of a write setup cycle.
        drive(1'b1, 1'b1, HTRANS_NONSEQ, 32'h80, 32'h0);
        drive(1'b0, 1'b0, HTRANS_IDLE, 32'h0, 32'h1234_5678);
        check("wrrst_pre_psel", {31'b0, psel}, 32'h1);
        #2;
        hresetn = 1'b0;
        #1;
        check("wrrst_psel",    {31'b0, psel},    32'h0);
        check("wrrst_penable", {31'b0, penable}, 32'h0);
        check("wrrst_hready",  {31'b0, hready},  32'h1);
        @(posedge hclk);
        #1;
        hresetn = 1'b1;
        idle_cycle();
        check("wrrst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("wrrst_after_psel", {31'b0, psel}, 32'h0);
        idle_cycle();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
